// File: rtl/dcmac_0_prbs_gen_tx_ts_if.sv
`default_nettype none
// ============================================================================
// dcmac_0_prbs_gen_tx_ts_if : request / payload bundle of the TX PRBS source
// Revision 1.0
// ============================================================================
interface dcmac_0_prbs_gen_tx_ts_if;
  logic          i_req_en;
  logic [2:0]    i_id;
  logic [7:0]    i_req_num;
  logic          i_inj_err;
  logic          i_ctx_clr;
  logic          o_vld;
  logic [2:0]    o_id;
  logic [7:0]    o_num_byte;
  logic [1535:0] o_dat;
  logic [31:0]   o_req_cnt;

  modport master (
    output i_req_en, i_id, i_req_num, i_inj_err, i_ctx_clr,
    input  o_vld, o_id, o_num_byte, o_dat, o_req_cnt
  );

  modport slave (
    input  i_req_en, i_id, i_req_num, i_inj_err, i_ctx_clr,
    output o_vld, o_id, o_num_byte, o_dat, o_req_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dcmac_0_prbs_gen_tx_ts.sv
`default_nettype none
// ============================================================================
// dcmac_0_prbs_gen_tx_ts : time-sliced PRBS16 / byte-counter payload source
// Revision 1.0
// ============================================================================
module dcmac_0_prbs_gen_tx_ts #(
  parameter int          COUNTER_MODE = 0,
  parameter logic [15:0] INIT_SEED    = 16'hACE1,
  parameter int          NUM_ID       = 8
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  dcmac_0_prbs_gen_tx_ts_if.slave bus
);
  localparam int c_max_bytes = 192;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic          w_accept;
  logic          r_s1_vld;
  logic [2:0]    r_s1_id;
  logic [7:0]    r_s1_num;
  logic          r_s1_inj;
  logic          r_s1_clr;
  logic [31:0]   r_req_cnt;
  logic [15:0]   r_ctx [8];
  logic [7:0]    w_num;
  logic [15:0]   w_seed;
  logic [15:0]   w_wb;
  logic [7:0]    w_gen [c_max_bytes];
  logic [1535:0] w_dat;
  logic          r_vld;
  logic [2:0]    r_id;
  logic [7:0]    r_num;
  logic [1535:0] r_dat;

  // Reset asserts immediately, releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_accept = bus.i_req_en && (int'(bus.i_id) < NUM_ID);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_id   <= '0;
      r_s1_num  <= '0;
      r_s1_inj  <= 1'b0;
      r_s1_clr  <= 1'b0;
      r_req_cnt <= '0;
    end else begin
      r_s1_vld <= w_accept;
      r_s1_id  <= bus.i_id;
      r_s1_num <= bus.i_req_num;
      r_s1_inj <= bus.i_inj_err;
      r_s1_clr <= bus.i_ctx_clr;
      if (w_accept) r_req_cnt <= r_req_cnt + 32'd1;
    end
  end

  // Contexts are flops read in the cycle after the previous write, so a
  // back-to-back request on the same ID always sees the fresh write-back.
  assign w_num  = (r_s1_num > 8'(c_max_bytes)) ? 8'(c_max_bytes) : r_s1_num;
  assign w_seed = r_s1_clr ? INIT_SEED : r_ctx[r_s1_id];

  generate
    if (COUNTER_MODE != 0) begin : g_counter
      always_comb begin
        w_gen = '{default: 8'h00};
        for (int k = 0; k < c_max_bytes; k++) begin
          w_gen[k] = w_seed[7:0] + 8'(k + 1);
        end
      end
    end else begin : g_prbs
      always_comb begin : p_lfsr
        logic [15:0] v_s;
        v_s   = w_seed;
        w_gen = '{default: 8'h00};
        for (int k = 0; k < c_max_bytes; k++) begin
          for (int b = 0; b < 8; b++) begin
            v_s = {v_s[14:0], v_s[15] ^ v_s[13] ^ v_s[12] ^ v_s[10]};
          end
          w_gen[k] = v_s[7:0];
        end
      end
    end
  endgenerate

  always_comb begin
    w_wb = w_seed;
    if (w_num == 8'd1) begin
      w_wb = {w_seed[7:0], w_gen[0]};
    end else if (w_num >= 8'd2) begin
      w_wb = {w_gen[w_num - 8'd2], w_gen[w_num - 8'd1]};
    end
  end

  // Corruption is applied after write-back selection so it stays in one beat
  always_comb begin
    w_dat = '0;
    for (int k = 0; k < c_max_bytes; k++) begin
      if (k < int'(w_num)) w_dat[8*k +: 8] = w_gen[k];
    end
    if (r_s1_inj && (w_num != 8'd0)) w_dat[0] = ~w_dat[0];
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld <= 1'b0;
      r_id  <= '0;
      r_num <= '0;
      r_dat <= '0;
      for (int i = 0; i < 8; i++) r_ctx[i] <= INIT_SEED;
    end else begin
      r_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_id           <= r_s1_id;
        r_num          <= w_num;
        r_dat          <= w_dat;
        r_ctx[r_s1_id] <= w_wb;
      end
    end
  end

  assign bus.o_vld      = r_vld;
  assign bus.o_id       = r_id;
  assign bus.o_num_byte = r_num;
  assign bus.o_dat      = r_dat;
  assign bus.o_req_cnt  = r_req_cnt;
endmodule
`default_nettype wire

// File: tb/tb_dcmac_0_prbs_gen_tx_ts.sv
`default_nettype none
// Bench: a counter-mode and a PRBS-mode instance share one directed stimulus
// stream; a per-ID continuous-stream model predicts every beat.
module tb_dcmac_0_prbs_gen_tx_ts;
  localparam int          NID    = 6;
  localparam logic [15:0] SEED_C = 16'h00FF;
  localparam logic [15:0] SEED_P = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   in_rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcmac_0_prbs_gen_tx_ts_if bus_c ();
  dcmac_0_prbs_gen_tx_ts_if bus_p ();

  dcmac_0_prbs_gen_tx_ts #(.COUNTER_MODE(1), .INIT_SEED(SEED_C), .NUM_ID(NID)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));
  dcmac_0_prbs_gen_tx_ts #(.COUNTER_MODE(0), .INIT_SEED(SEED_P), .NUM_ID(NID)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .bus(bus_p));

  typedef struct {
    int            due;
    logic [2:0]    id;
    logic [7:0]    num;
    logic [1535:0] dat_c;
    logic [1535:0] dat_p;
    bit            pc_en;
    logic [63:0]   pc;
    bit            pp_en;
    logic [7:0]    pp;
  } beat_t;

  beat_t       q[$];
  logic [15:0] m_lfsr [8];   // PRBS stream position per ID
  logic [7:0]  m_last [8];   // last counter byte emitted per ID
  logic [31:0] m_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_dat(string name, logic [1535:0] act, logic [1535:0] exp);
    checks++;
    if (act !== exp) begin
      int k;
      k = 0;
      while (k < 191 && act[8*k +: 8] === exp[8*k +: 8]) k++;
      errors++;
      $display("FAIL %s byte %0d act=%02h exp=%02h (cyc %0d)", name, k, act[8*k +: 8], exp[8*k +: 8], cyc);
    end
  endtask

  task automatic prbs_byte(inout logic [15:0] s, output logic [7:0] b);
    logic fb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      b  = {b[6:0], fb};
      s  = {s[14:0], fb};
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_lfsr[i] = SEED_P;
      m_last[i] = SEED_C[7:0];
    end
    m_cnt = 32'd0;
    q.delete();
  endtask

  task automatic drive(bit en, int id, int num, bit inj, bit clr);
    bus_c.i_req_en = en;    bus_p.i_req_en = en;
    bus_c.i_id = 3'(id);    bus_p.i_id = 3'(id);
    bus_c.i_req_num = 8'(num); bus_p.i_req_num = 8'(num);
    bus_c.i_inj_err = inj;  bus_p.i_inj_err = inj;
    bus_c.i_ctx_clr = clr;  bus_p.i_ctx_clr = clr;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic issue(int id, int num, bit inj = 1'b0, bit clr = 1'b0,
                       bit pc_en = 1'b0, logic [63:0] pc = 64'h0,
                       bit pp_en = 1'b0, logic [7:0] pp = 8'h00);
    beat_t      b;
    logic [2:0] ix;
    logic [7:0] pb;
    int         n;
    @(negedge clk);
    drive(1'b1, id, num, inj, clr);
    if (id < NID) begin
      ix = 3'(id);
      m_cnt = m_cnt + 32'd1;
      n = (num > 192) ? 192 : num;
      if (clr) begin
        m_lfsr[ix] = SEED_P;
        m_last[ix] = SEED_C[7:0];
      end
      b.dat_c = '0;
      b.dat_p = '0;
      for (int k = 0; k < n; k++) begin
        m_last[ix] = m_last[ix] + 8'd1;
        b.dat_c[8*k +: 8] = m_last[ix];
        prbs_byte(m_lfsr[ix], pb);
        b.dat_p[8*k +: 8] = pb;
      end
      if (inj && n > 0) begin
        b.dat_c[0] = ~b.dat_c[0];
        b.dat_p[0] = ~b.dat_p[0];
      end
      b.due = cyc + 2;
      b.id = ix;
      b.num = 8'(n);
      b.pc_en = pc_en; b.pc = pc;
      b.pp_en = pp_en; b.pp = pp;
      if (pc_en) chk("model_pin_c", b.dat_c[63:0], pc);
      if (pp_en) chk("model_pin_p", 64'(b.dat_p[7:0]), 64'(pp));
      q.push_back(b);
    end
  endtask

  always @(negedge clk) begin : p_compare
    bit    ev;
    beat_t b;
    if (!in_rst) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("vld_c", 64'(bus_c.o_vld), 64'(ev));
      chk("vld_p", 64'(bus_p.o_vld), 64'(ev));
      if (ev) begin
        b = q.pop_front();
        chk("id_c", 64'(bus_c.o_id), 64'(b.id));
        chk("id_p", 64'(bus_p.o_id), 64'(b.id));
        chk("num_c", 64'(bus_c.o_num_byte), 64'(b.num));
        chk("num_p", 64'(bus_p.o_num_byte), 64'(b.num));
        chk_dat("dat_c", bus_c.o_dat, b.dat_c);
        chk_dat("dat_p", bus_p.o_dat, b.dat_p);
        if (b.pc_en) chk("pin_c", bus_c.o_dat[63:0], b.pc);
        if (b.pp_en) chk("pin_p", 64'(bus_p.o_dat[7:0]), 64'(b.pp));
      end
    end
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    in_rst = 1'b0;
  endtask

  initial begin : p_stim
    model_reset();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_vld_c", 64'(bus_c.o_vld), 64'h0);
    chk("rst_vld_p", 64'(bus_p.o_vld), 64'h0);
    chk("rst_id_c", 64'(bus_c.o_id), 64'h0);
    chk("rst_num_c", 64'(bus_c.o_num_byte), 64'h0);
    chk_dat("rst_dat_p", bus_p.o_dat, '0);
    chk("rst_cnt_c", 64'(bus_c.o_req_cnt), 64'h0);
    reset_release();

    // back-to-back same ID, then interleaved IDs after a clear
    issue(0, 4, 0, 0, 1, 64'h03020100);
    issue(0, 2, 0, 0, 1, 64'h0504);
    issue(0, 3, 0, 1, 1, 64'h020100);
    issue(1, 1, 0, 0, 1, 64'h00);
    issue(0, 2, 0, 0, 1, 64'h0403);
    idle(2);

    // full-width PRBS slices, continuity across slices
    issue(2, 192, 0, 1, 0, 64'h0, 1, 8'hE4);
    issue(2, 192);
    idle(1);

    // clamp, zero-length beat, continuation
    issue(3, 200);
    issue(3, 0, 0, 0, 1, 64'h0);
    issue(3, 1, 0, 0, 1, 64'hC0);
    idle(1);

    // error injection confined to one beat
    issue(4, 8, 1, 0, 1, 64'h0706050403020101, 1, 8'hE5);
    issue(4, 8, 0, 0, 1, 64'h0F0E0D0C0B0A0908);
    idle(1);

    // out-of-range IDs dropped; clear without request ignored
    issue(6, 5);
    issue(1, 2, 0, 0, 1, 64'h0201);
    issue(7, 3);
    issue(1, 2, 0, 0, 1, 64'h0403);
    @(negedge clk);
    drive(1'b0, 1, 4, 1'b0, 1'b1);
    issue(1, 1, 0, 0, 1, 64'h05);
    idle(1);

    // mixed table, pairs of same-ID requests back-to-back
    begin
      int nums [12] = '{0, 1, 2, 3, 191, 192, 193, 255, 7, 16, 1, 0};
      for (int i = 0; i < 24; i++) begin
        issue((i / 2) % NID, nums[i % 12], (i == 7), (i == 5));
      end
    end
    idle(4);
    chk("req_cnt_c", 64'(bus_c.o_req_cnt), 64'(m_cnt));
    chk("req_cnt_p", 64'(bus_p.o_req_cnt), 64'(m_cnt));

    // asynchronous reset with beats in flight
    issue(0, 5);
    issue(0, 5);
    issue(2, 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("arst_vld_c", 64'(bus_c.o_vld), 64'h0);
    chk("arst_vld_p", 64'(bus_p.o_vld), 64'h0);
    chk("arst_cnt_c", 64'(bus_c.o_req_cnt), 64'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_release();
    issue(0, 2, 0, 0, 1, 64'h0100, 1, 8'hE4);
    issue(0, 2, 0, 1, 1, 64'h0100, 1, 8'hE4);
    issue(0, 2, 0, 0, 1, 64'h0302);
    idle(5);
    chk("post_cnt_c", 64'(bus_c.o_req_cnt), 64'd3);
    chk("post_cnt_p", 64'(bus_p.o_req_cnt), 64'(m_cnt));
    chk("drain", 64'(q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
